beep_pulse_driver: RTL and testbench

- Output-side counterpart of the button debouncer. The debouncer turns a long physical level into a one-cycle pulse; this block turns a one-cycle event pulse into long, human-perceivable outputs.
- It drives the stopwatch buzzer with a square-wave tone and a status LED for a burst of N beeps.
- Typical triggers are start/stop/lap events or alarm expiry from the timing core.

---
 rtl/stopwatch_pkg.sv | 27 ++
 rtl/tick_prescaler.sv | 34 +++
 rtl/beep_pulse_driver.sv | 131 +++++++++++++
 tb/tb_beep_pulse_driver.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: beep FSM state type, default timing constants
// and a counter-width helper.
// Optional build macro used by beep_pulse_driver: BEEP_RETRIGGER_EN.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } beep_state_t;

  // Board timing: 50 MHz system clock, 1 ms tick, 2 kHz buzzer tone.
  localparam int CLK_HZ  = 50_000_000;
  localparam int TICK_HZ = 1_000;
  localparam int TONE_HZ = 2_000;

  localparam int DEF_PRESCALE  = CLK_HZ / TICK_HZ;
  localparam int DEF_TONE_HALF = CLK_HZ / (2 * TONE_HZ);
  localparam int DEF_ON_TICKS  = 100;
  localparam int DEF_OFF_TICKS = 100;

  // Width of a counter that runs 0..maxv-1; never narrower than one bit.
  function automatic int cnt_w(input int maxv);
    return (maxv > 1) ? $clog2(maxv) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: one-cycle tick every PRESCALE enabled clk cycles.
// clr restarts the count at zero and suppresses a tick in that cycle.
module tick_prescaler
  import stopwatch_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = cnt_w(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_reg;

  // Count enabled cycles, wrapping to zero on the tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      if (cnt_reg == PRE_LAST) cnt_reg <= '0;
      else                     cnt_reg <= cnt_reg + PW'(1);
    end
  end

  assign tick = en && !clr && (cnt_reg == PRE_LAST);

endmodule

// File: rtl/beep_pulse_driver.sv
// Stretches a one-cycle event pulse into a burst of audible beeps: square-wave
// buzzer drive and a status LED during each ON phase, silent gaps in between.
// Build option: define BEEP_RETRIGGER_EN to let trig restart a running burst.
module beep_pulse_driver
  import stopwatch_pkg::*;
#(
  parameter int PRESCALE  = DEF_PRESCALE,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int TONE_HALF = DEF_TONE_HALF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trig,
  input  logic [3:0] burst_n,
  output logic       beep,
  output logic       led,
  output logic       busy
);

  localparam int KW = cnt_w((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS);
  localparam int TW = cnt_w(TONE_HALF);
  localparam logic [KW-1:0] ON_LAST   = KW'(ON_TICKS - 1);
  localparam logic [KW-1:0] OFF_LAST  = KW'(OFF_TICKS - 1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);

  beep_state_t   state_reg, state_next;
  logic [3:0]    beeps_left_reg;
  logic [KW-1:0] tick_cnt_reg;
  logic [TW-1:0] tone_cnt_reg;
  logic          beep_reg, led_reg, busy_reg;
  logic          tick, start, on_done, gap_done, enter_on;

  // Phase timebase; only runs while a burst is in progress.
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (state_reg != IDLE),
    .tick  (tick)
  );

  // Next-state logic: start (accepted trig) overrides every phase transition.
  always_comb begin
    state_next = state_reg;
`ifdef BEEP_RETRIGGER_EN
    start = trig;
`else
    start = trig && (state_reg == IDLE);
`endif
    on_done  = (state_reg == ON)  && tick && (tick_cnt_reg == ON_LAST);
    gap_done = (state_reg == GAP) && tick && (tick_cnt_reg == OFF_LAST);
    if (start) begin
      state_next = ON;
    end else begin
      case (state_reg)
        IDLE:    state_next = IDLE;
        ON:      if (on_done) state_next = (beeps_left_reg == 4'd1) ? IDLE : GAP;
        GAP:     if (gap_done) state_next = ON;
        default: state_next = IDLE;
      endcase
    end
  end

  assign enter_on = start || gap_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Remaining-beep count: latched on start, decremented on each ON->GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beeps_left_reg <= 4'd0;
    end else if (start) begin
      beeps_left_reg <= (burst_n == 4'd0) ? 4'd1 : burst_n;
    end else if (on_done && (beeps_left_reg != 4'd1)) begin
      beeps_left_reg <= beeps_left_reg - 4'd1;
    end
  end

  // Ticks elapsed within the current ON or GAP phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_reg <= '0;
    end else if (start || on_done || gap_done) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= tick_cnt_reg + KW'(1);
    end
  end

  // Tone generator: every ON phase starts high with a fresh half-period count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt_reg <= '0;
      beep_reg     <= 1'b0;
    end else if (state_next != ON) begin
      tone_cnt_reg <= '0;
      beep_reg     <= 1'b0;
    end else if (enter_on) begin
      tone_cnt_reg <= '0;
      beep_reg     <= 1'b1;
    end else if (tone_cnt_reg == TONE_LAST) begin
      tone_cnt_reg <= '0;
      beep_reg     <= ~beep_reg;
    end else begin
      tone_cnt_reg <= tone_cnt_reg + TW'(1);
    end
  end

  // Registered LED and busy flags, decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg  <= 1'b0;
      busy_reg <= 1'b0;
    end else begin
      led_reg  <= (state_next == ON);
      busy_reg <= (state_next != IDLE);
    end
  end

  assign beep = beep_reg;
  assign led  = led_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_beep_pulse_driver.sv
// Self-checking bench for beep_pulse_driver (PRESCALE=4, ON_TICKS=3,
// OFF_TICKS=2, TONE_HALF=2). Honours BEEP_RETRIGGER_EN when defined.
module tb_beep_pulse_driver;

  localparam int P    = 4;
  localparam int ONT  = 3;
  localparam int OFFT = 2;
  localparam int TH   = 2;
  localparam int ON_CYC  = ONT * P;            // 12
  localparam int PERIOD  = (ONT + OFFT) * P;   // 20

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trig = 1'b0;
  logic [3:0] burst_n = 4'd0;
  logic       beep, led, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural model: a burst is described only by its start interval and size.
  bit m_act = 1'b0;
  int m_t0  = 0;
  int m_n   = 0;

  typedef struct {
    logic [3:0] burst;
    int         busy_len;
    int         led_len;
    int         beep_len;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  beep_pulse_driver #(
    .PRESCALE  (P),
    .ON_TICKS  (ONT),
    .OFF_TICKS (OFFT),
    .TONE_HALF (TH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .trig    (trig),
    .burst_n (burst_n),
    .beep    (beep),
    .led     (led),
    .busy    (busy)
  );

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0b want=%0b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // Advance one clock; afterwards cyc names the interval following that edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected tone level d cycles into an ON phase (d starts at 1).
  function automatic logic tone_at(input int d);
    return (((d - 1) / TH) % 2) == 0;
  endfunction

  function automatic int burst_len(input int n);
    return n * ON_CYC + (n - 1) * OFFT * P;
  endfunction

  function automatic void model_out(input int c, output logic b, output logic l, output logic bp);
    int d, p;
    b = 1'b0; l = 1'b0; bp = 1'b0;
    if (m_act) begin
      d = c - m_t0 + 1;
      if (d >= 1 && d <= burst_len(m_n)) begin
        p  = (d - 1) % PERIOD;
        b  = 1'b1;
        l  = (p < ON_CYC);
        bp = l && tone_at(p + 1);
      end
    end
  endfunction

  initial begin
    logic [11:0] pat;
    logic eb, el, ebp;
    int nb, nl, nbp, first, last;
    bit accept;

    pat = 12'b1100_1100_1100;
    vecs[0] = '{4'd0,  12,  12,  6};
    vecs[1] = '{4'd1,  12,  12,  6};
    vecs[2] = '{4'd2,  32,  24,  12};
    vecs[3] = '{4'd3,  52,  36,  18};
    vecs[4] = '{4'd15, 292, 180, 90};

    // Reset holds everything low even with trig asserted.
    trig = 1'b1; burst_n = 4'd3;
    #1;
    check("rst_busy0", busy, 1'b0);
    check("rst_led0",  led,  1'b0);
    check("rst_beep0", beep, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_busy", busy, 1'b0);
      check("rst_led",  led,  1'b0);
      check("rst_beep", beep, 1'b0);
    end
    trig = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      check("idle_busy", busy, 1'b0);
      check("idle_led",  led,  1'b0);
      check("idle_beep", beep, 1'b0);
    end

    // Single beep, exact cycle pattern.
    burst_n = 4'd1; trig = 1'b1;
    step();
    trig = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      check("single_busy", busy, i <= 12);
      check("single_led",  led,  i <= 12);
      check("single_beep", beep, (i <= 12) ? pat[12 - i] : 1'b0);
      step();
    end

    // Two beeps: ON 12, GAP 8, ON 12 with the tone restarting high.
    burst_n = 4'd2; trig = 1'b1;
    step();
    trig = 1'b0; burst_n = 4'd9;
    for (int i = 1; i <= 34; i++) begin
      el = (i <= 12) || (i >= 21 && i <= 32);
      check("burst2_busy", busy, i <= 32);
      check("burst2_led",  led,  el);
      check("burst2_beep", beep, el ? pat[11 - ((i - 1) % PERIOD)] : 1'b0);
      step();
    end

    // trig during a running beep.
    burst_n = 4'd1; trig = 1'b1;
    step();
    trig = 1'b0;
    for (int i = 1; i <= 20; i++) begin
`ifdef BEEP_RETRIGGER_EN
      check("retrig_busy", busy, i <= 17);
      check("retrig_beep", beep, (i <= 5) ? pat[12 - i] : (i <= 17) ? pat[12 - (i - 5)] : 1'b0);
`else
      check("retrig_busy", busy, i <= 12);
      check("retrig_beep", beep, (i <= 12) ? pat[12 - i] : 1'b0);
`endif
      trig = (i == 5);
      step();
    end
    trig = 1'b0;

    // Asynchronous reset in the middle of a beep, then a clean restart.
    burst_n = 4'd3; trig = 1'b1;
    step();
    trig = 1'b0;
    for (int i = 1; i < 7; i++) step();
    check("abort_pre_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_led",  led,  1'b0);
    check("abort_beep", beep, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    check("abort_noresume", busy, 1'b0);
    burst_n = 4'd1; trig = 1'b1;
    step();
    trig = 1'b0;
    check("restart_beep", beep, 1'b1);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) nb++;
      step();
    end
    check_int("restart_len", nb, 12);

    // Table: burst sizes, checked by busy/led/beep cycle totals.
    foreach (vecs[v]) begin
      burst_n = vecs[v].burst; trig = 1'b1;
      step();
      trig = 1'b0; burst_n = 4'($urandom_range(0, 15));
      check("tbl_first_beep", beep, 1'b1);
      nb = 0; nl = 0; nbp = 0; first = -1; last = -1;
      for (int i = 1; i <= 310; i++) begin
        if (busy) begin
          nb++;
          if (first < 0) first = i;
          last = i;
        end
        if (led)  nl++;
        if (beep) nbp++;
        step();
      end
      check_int("tbl_busy_len", nb, vecs[v].busy_len);
      check_int("tbl_busy_end", last - first + 1, vecs[v].busy_len);
      check_int("tbl_led_len",  nl, vecs[v].led_len);
      check_int("tbl_beep_len", nbp, vecs[v].beep_len);
    end

    // Random trig/burst_n/reset traffic against the model.
    m_act = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        m_act = 1'b0;
        check("rnd_rst_busy", busy, 1'b0);
        check("rnd_rst_beep", beep, 1'b0);
        trig = 1'b0;
        @(posedge clk); #1; cyc++;
        rst_n = 1'b1;
      end
      trig = ($urandom_range(0, 9) == 0);
      burst_n = 4'($urandom_range(0, 4));
      model_out(cyc, eb, el, ebp);
`ifdef BEEP_RETRIGGER_EN
      accept = trig;
`else
      accept = trig && !eb;
`endif
      if (accept) begin
        m_act = 1'b1;
        m_t0  = cyc + 1;
        m_n   = (burst_n == 4'd0) ? 1 : int'(burst_n);
      end
      step();
      model_out(cyc, eb, el, ebp);
      check("rnd_busy", busy, eb);
      check("rnd_led",  led,  el);
      check("rnd_beep", beep, ebp);
    end
    trig = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
